// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB slave-port signal bundle.
// The master side also drives the interconnect-level hready.
interface ahb_slave_mem_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB slave responder backed by a word-organised RAM.
// Define AHB_SLV_ERROR_EN to build the two-cycle ERROR response for bad accesses.
module ahb_slave_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MEM_BYTES   = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_slave_mem_if.slave bus
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef AHB_SLV_ERROR_EN
    typedef enum logic [2:0] {IDLE, DATA, WAIT, ERR1, ERR2} state_t;
`else
    typedef enum logic [2:0] {IDLE, DATA, WAIT} state_t;
`endif

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic [31:0]   mem [WORDS];
    logic [IW-1:0] idx_q;
    logic [1:0]    lo_q, size_q;
    logic          write_q, oor_q;
    logic [31:0]   off;
    logic          oor, mis, accept, readyout;
    logic [1:0]    lo_eff, size_eff, resp;
    logic [3:0]    lanes;
    logic [31:0]   rdata;
    logic          unused;

    assign off    = bus.haddr - ADDR_BASE;
    assign oor    = off >= 32'(MEM_BYTES);
    assign mis    = (bus.hsize == 3'b001 && bus.haddr[0])
                 || (bus.hsize == 3'b010 && bus.haddr[1:0] != 2'b00)
                 || (bus.hsize > 3'b010);
    assign accept = readyout && bus.hsel && bus.hready && bus.htrans[1];
    assign unused = ^{bus.hburst, bus.htrans[0]};

`ifdef AHB_SLV_ERROR_EN
    logic bad;
    assign bad      = oor || mis;
    assign lo_eff   = bus.haddr[1:0];
    assign size_eff = bus.hsize[1:0];
`else
    // Misaligned or oversized accesses degrade to an aligned word access.
    assign lo_eff   = mis ? 2'b00 : bus.haddr[1:0];
    assign size_eff = mis ? 2'b10 : bus.hsize[1:0];
`endif

    assign bus.hreadyout = readyout;
    assign bus.hresp     = resp;
    assign bus.hrdata    = rdata;

    // handshake and read-data outputs decoded from the current state
    always_comb begin
        readyout = 1'b1;
        resp     = 2'b00;
        rdata    = '0;
        case (state)
            WAIT: readyout = 1'b0;
            DATA: begin
                if (!write_q && !oor_q) rdata = mem[idx_q];
            end
`ifdef AHB_SLV_ERROR_EN
            ERR1: begin
                readyout = 1'b0;
                resp     = 2'b01;
            end
            ERR2: resp = 2'b01;
`endif
            default: ;
        endcase
    end

    // next state: drain the current data phase, then take a new transfer
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            WAIT: begin
                if (cnt == 4'd0) state_nx = DATA;
                else             cnt_nx   = cnt - 4'd1;
            end
`ifdef AHB_SLV_ERROR_EN
            ERR1: state_nx = ERR2;
`endif
            default: state_nx = IDLE;
        endcase
        if (accept) begin
`ifdef AHB_SLV_ERROR_EN
            if (bad) begin
                state_nx = ERR1;
            end else
`endif
            if (WAIT_STATES > 0) begin
                state_nx = WAIT;
                cnt_nx   = CNT_INIT;
            end else begin
                state_nx = DATA;
            end
        end
    end

    // byte-lane enables for the registered little-endian access
    always_comb begin
        lanes = 4'b1111;
        case (size_q)
            2'b00:   lanes = 4'b0001 << lo_q;
            2'b01:   lanes = lo_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // state register and address-phase capture
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            size_q  <= 2'b10;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                idx_q   <= off[IW+1:2];
                lo_q    <= lo_eff;
                size_q  <= size_eff;
                write_q <= bus.hwrite;
                oor_q   <= oor;
            end
        end
    end

    // RAM write on the completion edge; a reset drops the pending write
    always_ff @(posedge hclk) begin
        if (!hreset && state == DATA && write_q && !oor_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

endmodule
